// File: rtl/boot_sequencer.sv
// Boot-time loader: sends one SPI READ frame, then streams WORD_COUNT 16-bit words from storage
// into instruction/data memory through a one-entry valid/ready write buffer.
module boot_sequencer #(
  parameter int unsigned WORD_COUNT = 32768,
  parameter int unsigned ADDR_W     = 15,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [23:0] START_ADDR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              spi_miso,
  input  logic              mem_wr_ready,
  output logic              boot_en,
  output logic              spi_mosi,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_wr_valid,
  output logic              is_booted,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCmd,
    StData,
    StDrain,
    StDone,
    StErr
  } state_e;

  localparam logic [31:0]     Frame   = {READ_CMD, START_ADDR};
  localparam int unsigned     LastIdx = WORD_COUNT - 1;
  localparam logic [ADDR_W:0] WordOne = 1;

  state_e              state_q, state_d;
  logic [31:0]         frame_q, frame_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [15:0]         shift_q, shift_d;
  logic                boot_en_q, boot_en_d;
  logic                mosi_q, mosi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                booted_q, booted_d;
  logic                err_q, err_d;
  logic [15:0]         word;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    boot_en_d  = boot_en_q;
    mosi_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    booted_d   = booted_q;
    err_d      = err_q;
    word       = {shift_q[14:0], spi_miso};

    // A load later in this block overrides the acceptance clear.
    if (valid_q && mem_wr_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSetup;
          boot_en_d  = 1'b1;
          mosi_d     = Frame[31];
          frame_d    = Frame;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      StSetup: begin
        // SCK is held off this cycle, so bit 31 is presented again in the first CMD cycle.
        state_d = StCmd;
        mosi_d  = frame_q[31];
        frame_d = {frame_q[30:0], 1'b0};
      end
      StCmd: begin
        if (bit_cnt_q == 5'd31) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end else begin
          mosi_d    = frame_q[31];
          frame_d   = {frame_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      StData: begin
        shift_d = word;
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = '0;
          if (valid_q && !mem_wr_ready) begin
            err_d     = 1'b1;
            boot_en_d = 1'b0;
            state_d   = StErr;
          end else begin
            data_d     = word;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            valid_d    = 1'b1;
            word_cnt_d = word_cnt_q + WordOne;
            if (32'(word_cnt_q) == LastIdx) begin
              boot_en_d = 1'b0;
              state_d   = StDrain;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      StDrain: begin
        if (!valid_q) begin
          booted_d = 1'b1;
          state_d  = StDone;
        end
      end
      StDone, StErr: begin
        boot_en_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      boot_en_q  <= 1'b0;
      mosi_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      booted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      boot_en_q  <= boot_en_d;
      mosi_q     <= mosi_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      booted_q   <= booted_d;
      err_q      <= err_d;
    end
  end

  assign boot_en      = boot_en_q;
  assign spi_mosi     = mosi_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_wr_valid = valid_q;
  assign is_booted    = booted_q;
  assign boot_err     = err_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: a cycle-count based model of the boot timeline checked every cycle,
// plus literal expectations for frame bits, write log, latencies and error timing.
module tb_boot_sequencer;

  localparam int unsigned WC = 4;
  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          spi_miso = 1'b0;
  logic          mem_wr_ready = 1'b1;
  logic          boot_en;
  logic          spi_mosi;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wr_valid;
  logic          is_booted;
  logic          boot_err;

  always #5 clk = ~clk;

  boot_sequencer #(
    .WORD_COUNT(WC),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .spi_miso    (spi_miso),
    .mem_wr_ready(mem_wr_ready),
    .boot_en     (boot_en),
    .spi_mosi    (spi_mosi),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wr_valid(mem_wr_valid),
    .is_booted   (is_booted),
    .boot_err    (boot_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the boot is a timeline counted from the start edge; only the buffer and the
  // sticky flags need real state.
  logic [31:0] frame_v = 32'h03000000;
  logic [15:0] words [WC];
  bit          chk_en = 1'b0;
  bit          m_run, m_drain, m_done, m_err, m_booted, m_valid;
  int          m_t, m_addr, m_w, m_idx;
  logic [15:0] m_data;
  bit          m_nv;
  logic        em;

  int          cyc = 0;
  int          run_s, boot_en_cnt, first_en_cyc, booted_cyc, err_cyc;
  int          acc_cyc [$];
  int          acc_addr [$];
  logic [15:0] acc_data [$];
  logic [31:0] mosi_seq;
  logic        setup_mosi;

  always @(posedge clk) begin
    cyc++;
    if (chk_en) begin
      if (mem_wr_valid === 1'b1 && mem_wr_ready) begin
        acc_cyc.push_back(cyc);
        acc_addr.push_back(int'(mem_addr));
        acc_data.push_back(mem_data);
      end
      if (boot_en === 1'b1) boot_en_cnt++;
    end
    if (rst) begin
      m_run = 0; m_drain = 0; m_done = 0; m_err = 0; m_booted = 0; m_valid = 0;
      m_t = 0; m_addr = 0; m_data = '0;
    end else begin
      m_nv = m_valid && !mem_wr_ready;
      if (m_run) begin
        if (m_t >= 49 && (m_t - 33) % 16 == 0) begin
          m_w = (m_t - 33) / 16 - 1;
          if (m_valid && !mem_wr_ready) begin
            m_err = 1; m_run = 0;
          end else begin
            m_nv = 1; m_data = words[m_w]; m_addr = m_w;
            if (m_w == WC - 1) begin m_run = 0; m_drain = 1; end
          end
        end
        m_t++;
      end else if (m_drain) begin
        if (!m_valid) begin m_booted = 1; m_drain = 0; m_done = 1; end
      end else if (!m_done && !m_err && start) begin
        m_run = 1; m_t = 1;
      end
      m_valid = m_nv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      em = 1'b0;
      if (m_run && m_t == 1) em = frame_v[31];
      else if (m_run && m_t >= 2 && m_t <= 33) em = frame_v[33-m_t];
      check("boot_en", 32'(boot_en), 32'(m_run));
      check("spi_mosi", 32'(spi_mosi), 32'(em));
      check("mem_wr_valid", 32'(mem_wr_valid), 32'(m_valid));
      check("mem_addr", 32'(mem_addr), 32'(AW'(m_addr)));
      check("mem_data", 32'(mem_data), 32'(m_data));
      check("is_booted", 32'(is_booted), 32'(m_booted));
      check("boot_err", 32'(boot_err), 32'(m_err));
      if (m_run && m_t == 1) setup_mosi = spi_mosi;
      if (m_run && m_t >= 2 && m_t <= 33) mosi_seq = {mosi_seq[30:0], spi_mosi};
      if (boot_en === 1'b1 && first_en_cyc < 0) first_en_cyc = cyc;
      if (is_booted === 1'b1 && booted_cyc < 0) booted_cyc = cyc;
      if (boot_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end
    if (m_run && m_t >= 34) begin
      m_idx = m_t - 34;
      spi_miso = words[m_idx/16][15-(m_idx%16)];
    end else begin
      spi_miso = 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b1;
    mem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_boot_en", 32'(boot_en), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_valid", 32'(mem_wr_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_booted", 32'(is_booted), 32'd0);
    check("rst_err", 32'(boot_err), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  // t counts cycles after the start edge (t=1 is the SETUP cycle). ready is low for
  // t in [low_from, low_from+low_len); rst is asserted for the single cycle t=rst_at.
  task automatic run_boot(input int low_from, input int low_len, input int rst_at,
                          input int cycles);
    int t;
    acc_cyc.delete(); acc_addr.delete(); acc_data.delete();
    boot_en_cnt = 0; first_en_cyc = -1; booted_cyc = -1; err_cyc = -1;
    mosi_seq = '0; setup_mosi = 1'bx;
    mem_wr_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_s = cyc;
    for (int k = 0; k < cycles; k++) begin
      t = cyc - run_s + 1;
      if (t == rst_at) check("valid_before_rst", 32'(mem_wr_valid), 32'd1);
      if (t == rst_at + 1) begin
        check("boot_en_after_rst", 32'(boot_en), 32'd0);
        check("valid_after_rst", 32'(mem_wr_valid), 32'd0);
      end
      mem_wr_ready = !(t >= low_from && t < low_from + low_len);
      rst = (t == rst_at);
      @(negedge clk);
    end
    rst = 1'b0;
    mem_wr_ready = 1'b1;
  endtask

  task automatic check_writes(input string tag, input logic [15:0] exp0, input logic [15:0] exp1,
                              input logic [15:0] exp2, input logic [15:0] exp3);
    logic [15:0] e [4];
    e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3;
    check({tag, "_wr_count"}, 32'(acc_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_wr_addr%0d", tag, i),
            (i < acc_addr.size()) ? 32'(acc_addr[i]) : 32'hxxxxxxxx, 32'(i));
      check($sformatf("%s_wr_data%0d", tag, i),
            (i < acc_data.size()) ? 32'(acc_data[i]) : 32'hxxxxxxxx, 32'(e[i]));
    end
  endtask

  initial begin
    do_reset();

    // Command frame and data path with an always-ready memory.
    words[0] = 16'hA5C3; words[1] = 16'h0001; words[2] = 16'hFFFF; words[3] = 16'h8000;
    run_boot(0, 0, -1, 110);
    check("first_en_latency", 32'(first_en_cyc - run_s), 32'd0);
    check("setup_mosi", 32'(setup_mosi), 32'd0);
    check("cmd_mosi_seq", mosi_seq, 32'h03000000);
    check("boot_en_cycles", 32'(boot_en_cnt), 32'd97);
    check_writes("dp", 16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000);
    check("dp_first_accept", (acc_cyc.size() > 0) ? 32'(acc_cyc[0] - run_s) : 32'hx, 32'd50);
    check("dp_booted_time", 32'(booted_cyc - run_s), 32'd99);
    check("dp_booted_after_accept",
          (acc_cyc.size() == 4) ? 32'(booted_cyc - acc_cyc[3]) : 32'hx, 32'd1);
    check("dp_err", 32'(boot_err), 32'd0);
    check("dp_booted", 32'(is_booted), 32'd1);

    // Backpressure within one word time: no error, word 0 accepted late.
    do_reset();
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    run_boot(50, 10, -1, 110);
    check_writes("bp", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    check("bp_first_accept", (acc_cyc.size() > 0) ? 32'(acc_cyc[0] - run_s) : 32'hx, 32'd60);
    check("bp_err", 32'(boot_err), 32'd0);
    check("bp_booted", 32'(is_booted), 32'd1);

    // Overrun: word 1 completes while word 0 is still pending.
    do_reset();
    words[0] = 16'h0F0F; words[1] = 16'hCAFE; words[2] = 16'h1111; words[3] = 16'h2222;
    run_boot(50, 16, -1, 110);
    check("ovr_err_time", 32'(err_cyc - run_s), 32'd65);
    check("ovr_boot_en_cycles", 32'(boot_en_cnt), 32'd65);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_err_sticky", 32'(boot_err), 32'd1);
    check("ovr_booted", 32'(is_booted), 32'd0);
    check("ovr_boot_en", 32'(boot_en), 32'd0);

    // Mid-transfer reset with a word pending, then a full clean reboot.
    do_reset();
    words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506; words[3] = 16'h0708;
    run_boot(66, 10, 70, 80);
    check("mrst_boot_en_cycles", 32'(boot_en_cnt), 32'd70);
    check("mrst_booted", 32'(is_booted), 32'd0);
    run_boot(0, 0, -1, 110);
    check("mrst_cmd_mosi_seq", mosi_seq, 32'h03000000);
    check_writes("mrst", 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    check("mrst_booted_after", 32'(is_booted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
